// File: rtl/i2c_spi_sequencer.sv
// I2C-to-SPI transaction sequencer.
// Takes one framed I2C write: a header byte, then payload bytes. Each payload
// byte becomes one SPI byte transfer inside a chip-select window. Optional
// dummy 0x00 read transfers follow the payload. Captured MISO bytes are queued
// in a small first-word-fall-through FIFO that the I2C read path drains.
module i2c_spi_sequencer #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  input  logic       spi_done,
  input  logic [7:0] spi_rx,
  output logic       spi_cs_n,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int         AW        = $clog2(RX_DEPTH);
  localparam logic [7:0] SETUP_END = (CS_SETUP > 0) ? 8'(CS_SETUP - 1) : 8'd0;
  localparam logic [7:0] HOLD_END  = 8'(CS_HOLD);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(RX_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAIT, S_XFER, S_DUMMY, S_HOLD
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        cap;
  logic        last;
  logic [3:0]  dcnt;

  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr_fire, push_req, push, pop, full;

  assign wr_ready = (state == S_IDLE) || (state == S_WAIT);
  assign busy     = (state != S_IDLE);
  assign wr_fire  = wr_valid & wr_ready;

  // A capture only exists while a transfer is in flight; stray spi_done is ignored.
  assign push_req = (state == S_XFER) & spi_done & cap;
  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign push     = push_req & (~full | pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  // Frame sequencing: chip select window, byte launches, dummy reads, overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      spi_cs_n  <= 1'b1;
      spi_start <= 1'b0;
      spi_tx    <= 8'h00;
      cnt       <= 8'd0;
      cap       <= 1'b0;
      last      <= 1'b0;
      dcnt      <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      if (push_req && full && !pop) overflow <= 1'b1;
      case (state)
        S_IDLE: if (wr_fire) begin
          cap      <= wr_data[7];
          dcnt     <= wr_data[3:0];
          last     <= wr_last;
          overflow <= 1'b0;
          spi_cs_n <= 1'b0;
          cnt      <= 8'd0;
          if (CS_SETUP == 0) state <= wr_last ? S_DUMMY : S_WAIT;
          else               state <= S_SETUP;
        end
        S_SETUP: begin
          if (cnt == SETUP_END) state <= last ? S_DUMMY : S_WAIT;
          else                  cnt   <= cnt + 8'd1;
        end
        S_WAIT: if (wr_fire) begin
          spi_tx    <= wr_data;
          last      <= wr_last;
          spi_start <= 1'b1;
          state     <= S_XFER;
        end
        S_XFER: if (spi_done) begin
          cnt <= 8'd0;
          if (!last)           state <= S_WAIT;
          else if (dcnt != '0) state <= S_DUMMY;
          else                 state <= S_HOLD;
        end
        S_DUMMY: begin
          if (dcnt == '0) begin
            cnt   <= 8'd0;
            state <= S_HOLD;
          end else begin
            spi_tx    <= 8'h00;
            spi_start <= 1'b1;
            dcnt      <= dcnt - 4'd1;
            state     <= S_XFER;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_END) begin
            spi_cs_n <= 1'b1;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Readback FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; stale entries are never visible because rd_data masks on empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= spi_rx;
  end

endmodule

// File: tb/tb_i2c_spi_sequencer.sv
// Directed bench for i2c_spi_sequencer (CS_SETUP=2, CS_HOLD=2, RX_DEPTH=4).
module tb_i2c_spi_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       wr_ready;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic       spi_done = 1'b0;
  logic [7:0] spi_rx = 8'h00;
  logic       spi_cs_n;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready = 1'b0;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  bit tmo = 1'b0;

  logic [7:0] tx_log [$];
  logic [7:0] rx_q [$];

  int start_total = 0;
  int rise_total  = 0;
  int run         = 0;
  int last_run    = 0;

  i2c_spi_sequencer #(.CS_SETUP(2), .CS_HOLD(2), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_done(spi_done), .spi_rx(spi_rx),
    .spi_cs_n(spi_cs_n),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Counts start pulses, cs_n low run lengths and cs_n rising edges.
  always @(negedge clk) begin
    if (spi_start === 1'b1) start_total <= start_total + 1;
    if (spi_cs_n === 1'b0) run <= run + 1;
    else if (run != 0) begin
      last_run   <= run;
      run        <= 0;
      rise_total <= rise_total + 1;
    end
  end

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    logic acc;
    n = 0;
    wr_valid = 1'b1; wr_data = d; wr_last = l;
    do begin
      acc = wr_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) tmo = 1'b1;
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic serve(input int n, input int lat, input int pop_from);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (spi_start !== 1'b1 && w < 300) begin @(posedge clk); #1; w++; end
      if (spi_start !== 1'b1) begin tmo = 1'b1; return; end
      tx_log.push_back(spi_tx);
      repeat (lat) begin @(posedge clk); #1; end
      spi_done = 1'b1;
      if (rx_q.size() > 0) spi_rx = rx_q.pop_front();
      else spi_rx = 8'h00;
      if (i >= pop_from) rd_ready = 1'b1;
      @(posedge clk); #1;
      spi_done = 1'b0; rd_ready = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 300) begin @(posedge clk); #1; w++; end
    if (busy !== 1'b0) tmo = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", spi_cs_n); end
    checks++; if (spi_start !== 1'b0) begin failures++; $display("FAIL reset_spi_start got=%b exp=0", spi_start); end
    checks++; if (spi_tx !== 8'h00) begin failures++; $display("FAIL reset_spi_tx got=%h exp=00", spi_tx); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin failures++; $display("FAIL post_reset_idle busy=%b wr_ready=%b exp busy=0 wr_ready=1", busy, wr_ready); end
  endtask

  task automatic test_write_frame();
    int s0;
    logic [7:0] exp_tx [2];
    exp_tx = '{8'hA5, 8'h3C};
    tmo = 1'b0; tx_log.delete(); s0 = start_total;
    fork
      begin send_byte(8'h00, 1'b0); send_byte(8'hA5, 1'b0); send_byte(8'h3C, 1'b1); end
      serve(2, 2, 99);
    join
    wait_idle();
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL write_timeout got=%b exp=0", tmo); end
    checks++; if (start_total - s0 !== 2) begin failures++; $display("FAIL write_starts got=%0d exp=2", start_total - s0); end
    checks++; if (tx_log.size() !== 2) begin failures++; $display("FAIL write_tx_count got=%0d exp=2", tx_log.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) begin
        failures++; $display("FAIL write_tx[%0d] got=%h exp=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx[i]);
      end
    end
    checks++; if (last_run !== 13) begin failures++; $display("FAIL write_cs_low_cycles got=%0d exp=13", last_run); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL write_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL write_end cs_n=%b busy=%b exp 1/0", spi_cs_n, busy); end
  endtask

  task automatic test_dummy_capture();
    int s0;
    logic [7:0] exp_tx [3];
    logic [7:0] exp_rx [3];
    exp_tx = '{8'h9F, 8'h00, 8'h00};
    exp_rx = '{8'h11, 8'h22, 8'h33};
    tmo = 1'b0; tx_log.delete(); s0 = start_total;
    rx_q = '{8'h11, 8'h22, 8'h33};
    fork
      begin send_byte(8'h82, 1'b0); send_byte(8'h9F, 1'b1); end
      serve(3, 2, 99);
    join
    wait_idle();
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL dummy_timeout got=%b exp=0", tmo); end
    checks++; if (start_total - s0 !== 3) begin failures++; $display("FAIL dummy_starts got=%0d exp=3", start_total - s0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) begin
        failures++; $display("FAIL dummy_tx[%0d] got=%h exp=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx[i]);
      end
    end
    checks++; if (last_run !== 17) begin failures++; $display("FAIL dummy_cs_low_cycles got=%0d exp=17", last_run); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rx[i]) begin
        failures++; $display("FAIL dummy_pop[%0d] valid=%b data=%h exp valid=1 data=%h", i, rd_valid, rd_data, exp_rx[i]);
      end
      rd_ready = 1'b1; @(posedge clk); #1; rd_ready = 1'b0;
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL dummy_drained got=%b exp=0", rd_valid); end
    rd_ready = 1'b1; @(posedge clk); #1; rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin failures++; $display("FAIL pop_empty valid=%b data=%h exp 0/00", rd_valid, rd_data); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_rx [4];
    exp_rx = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    tmo = 1'b0; tx_log.delete();
    rx_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    fork
      begin send_byte(8'h85, 1'b0); send_byte(8'h05, 1'b1); end
      serve(6, 2, 99);
    join
    wait_idle();
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL ovf_timeout got=%b exp=0", tmo); end
    checks++; if (tx_log.size() !== 6) begin failures++; $display("FAIL ovf_xfers got=%0d exp=6", tx_log.size()); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA0) begin failures++; $display("FAIL ovf_head valid=%b data=%h exp 1/a0", rd_valid, rd_data); end
    send_byte(8'h00, 1'b1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear_on_header got=%b exp=0", overflow); end
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rx[i]) begin
        failures++; $display("FAIL ovf_pop[%0d] valid=%b data=%h exp valid=1 data=%h", i, rd_valid, rd_data, exp_rx[i]);
      end
      rd_ready = 1'b1; @(posedge clk); #1; rd_ready = 1'b0;
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", rd_valid); end
  endtask

  task automatic test_empty_frame();
    int s0;
    tmo = 1'b0; s0 = start_total;
    send_byte(8'h00, 1'b1);
    checks++; if (spi_cs_n !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL empty_active cs_n=%b busy=%b exp 0/1", spi_cs_n, busy); end
    wait_idle();
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL empty_timeout got=%b exp=0", tmo); end
    checks++; if (start_total - s0 !== 0) begin failures++; $display("FAIL empty_starts got=%0d exp=0", start_total - s0); end
    checks++; if (last_run !== 6) begin failures++; $display("FAIL empty_cs_low_cycles got=%0d exp=6", last_run); end
    checks++; if (busy !== 1'b0 || spi_cs_n !== 1'b1) begin failures++; $display("FAIL empty_end busy=%b cs_n=%b exp 0/1", busy, spi_cs_n); end
  endtask

  task automatic test_reset_mid_xfer();
    int s0;
    tmo = 1'b0; tx_log.delete();
    rx_q = '{8'h51, 8'h52};
    fork
      begin
        send_byte(8'h80, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b1);
      end
      serve(2, 2, 99);
    join
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL rstx_timeout got=%b exp=0", tmo); end
    checks++; if (spi_start !== 1'b1 || spi_tx !== 8'h03) begin failures++; $display("FAIL rstx_third_start start=%b tx=%h exp 1/03", spi_start, spi_tx); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h51) begin failures++; $display("FAIL rstx_fifo_before valid=%b data=%h exp 1/51", rd_valid, rd_data); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL rstx_cs_n got=%b exp=1", spi_cs_n); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rstx_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstx_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    s0 = start_total;
    spi_done = 1'b1; spi_rx = 8'h77;
    @(posedge clk); #1;
    spi_done = 1'b0;
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || spi_cs_n !== 1'b1) begin failures++; $display("FAIL rstx_late_done valid=%b busy=%b cs_n=%b exp 0/0/1", rd_valid, busy, spi_cs_n); end
    checks++; if (start_total - s0 !== 0 || overflow !== 1'b0) begin failures++; $display("FAIL rstx_quiet starts=%0d ovf=%b exp 0/0", start_total - s0, overflow); end
  endtask

  task automatic test_gaps_full_pushpop();
    int s0, r0;
    logic [7:0] exp_rx [4];
    exp_rx = '{8'hC2, 8'hC3, 8'hC4, 8'hC5};
    tmo = 1'b0; tx_log.delete(); s0 = start_total; r0 = rise_total;
    rx_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    fork
      begin
        send_byte(8'h80, 1'b0);
        for (int i = 0; i < 6; i++) begin
          send_byte(8'hB0 + 8'(i), (i == 5));
          if (i < 5) repeat (5) begin @(posedge clk); #1; end
        end
      end
      serve(6, 2, 4);
    join
    wait_idle();
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL gap_timeout got=%b exp=0", tmo); end
    checks++; if (start_total - s0 !== 6) begin failures++; $display("FAIL gap_starts got=%0d exp=6", start_total - s0); end
    checks++; if (rise_total - r0 !== 1) begin failures++; $display("FAIL gap_cs_rises got=%0d exp=1", rise_total - r0); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL gap_overflow got=%b exp=0", overflow); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== 8'hB0 + 8'(i)) begin
        failures++; $display("FAIL gap_tx[%0d] got=%h exp=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, 8'hB0 + 8'(i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rx[i]) begin
        failures++; $display("FAIL gap_pop[%0d] valid=%b data=%h exp valid=1 data=%h", i, rd_valid, rd_data, exp_rx[i]);
      end
      rd_ready = 1'b1; @(posedge clk); #1; rd_ready = 1'b0;
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL gap_drained got=%b exp=0", rd_valid); end
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_dummy_capture();
    test_overflow();
    test_empty_frame();
    test_reset_mid_xfer();
    test_gaps_full_pushpop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
